seq_fsm_param: RTL

Parametrised successor to the team's 4-state cyclic sequencer. It steps a state index through N_STATES positions whenever an advance condition is present. It adds up/down direction, four end-of-range modes (wrap, saturate, bounce, one-shot), synchronous load, and optional edge-qualified advance. It is a drop-in sequencing core for lab control paths that drive the display or mux from the state index.

---
 rtl/seq_fsm_param.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_fsm_param.sv
// +-----------------------------------------------------------------------------+
// | seq_fsm_param: N-state up/down sequencer with wrap/saturate/bounce/one-shot |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module seq_fsm_param #(
  parameter int N_STATES = 4,
  parameter int COND_W   = 2,
  parameter bit EDGE     = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [COND_W-1:0]           conditions,
  input  logic                        dir,
  input  logic [1:0]                  mode,
  input  logic                        load,
  input  logic [$clog2(N_STATES)-1:0] load_val,
  output logic [$clog2(N_STATES)-1:0] out,
  output logic                        wrap,
  output logic                        at_term,
  output logic                        stopped
);

  localparam int            SW   = $clog2(N_STATES);
  localparam logic [SW-1:0] LAST = SW'(N_STATES - 1);

  localparam logic [1:0] C_MODE_WRAP    = 2'b00;
  localparam logic [1:0] C_MODE_SAT     = 2'b01;
  localparam logic [1:0] C_MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] C_MODE_ONESHOT = 2'b11;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  logic [SW-1:0] out_q, out_d;
  logic          wrap_q, wrap_d;
  logic          stopped_q, stopped_d;
  logic          prev_any_q, prev_any_d;
  dir_e          bdir_q, bdir_d;

  logic          w_any;
  logic          w_adv;
  logic          w_eff_dn;
  logic          w_term;
  logic          w_halted;
  logic [SW-1:0] w_load_clamped;

  // Only non-power-of-two ranges can carry a load value past the last state.
  if (2**SW != N_STATES) begin : g_clamp
    assign w_load_clamped = (load_val > LAST) ? LAST : load_val;
  end else begin : g_noclamp
    assign w_load_clamped = load_val;
  end

  assign w_any    = |conditions;
  assign w_adv    = EDGE ? (w_any & ~prev_any_q) : w_any;
  assign w_eff_dn = (mode == C_MODE_BOUNCE) ? (bdir_q == DIR_DN) : dir;
  assign w_term   = w_eff_dn ? (out_q == '0) : (out_q == LAST);
  assign w_halted = stopped_q && (mode == C_MODE_ONESHOT);

  always_comb begin
    out_d      = out_q;
    wrap_d     = 1'b0;
    stopped_d  = w_halted;
    bdir_d     = bdir_q;
    prev_any_d = w_any;

    if (load) begin
      out_d     = w_load_clamped;
      stopped_d = 1'b0;
      bdir_d    = DIR_UP;
    end else if (w_adv && !w_halted) begin
      if (!w_term) begin
        out_d = w_eff_dn ? (out_q - SW'(1)) : (out_q + SW'(1));
      end else begin
        case (mode)
          C_MODE_WRAP: begin
            out_d  = w_eff_dn ? LAST : '0;
            wrap_d = 1'b1;
          end
          C_MODE_BOUNCE: begin
            // Reverse and take one step back so the terminal is not repeated.
            bdir_d = (bdir_q == DIR_UP) ? DIR_DN : DIR_UP;
            out_d  = w_eff_dn ? SW'(1) : (LAST - SW'(1));
            wrap_d = 1'b1;
          end
          C_MODE_ONESHOT: begin
            stopped_d = 1'b1;
          end
          default: begin
            out_d = out_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= '0;
      wrap_q     <= 1'b0;
      stopped_q  <= 1'b0;
      prev_any_q <= 1'b0;
      bdir_q     <= DIR_UP;
    end else begin
      out_q      <= out_d;
      wrap_q     <= wrap_d;
      stopped_q  <= stopped_d;
      prev_any_q <= prev_any_d;
      bdir_q     <= bdir_d;
    end
  end

  assign out     = out_q;
  assign wrap    = wrap_q;
  assign at_term = w_term;
  assign stopped = stopped_q;

endmodule

`default_nettype wire
